// File: rtl/icache_resp.sv
// icache_resp: direct-mapped 4-word-line icache responder; fetch side req/addr/inv -> instr/done/stall/err, memory side mem_addr/mem_rd -> mem_data/mem_valid
module icache_resp #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic        inv,
  output logic [15:0] instr,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  input  logic        mem_valid
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TW = 13 - INDEX_BITS;
  localparam logic [15:0] NOP = 16'h0800;
  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;
  state_t state, state_nx;
  logic [LINES-1:0] valid;
  logic [TW-1:0] tags [LINES];
  logic [15:0] data [LINES][4];
  logic [TW-1:0] tag_l;
  logic [INDEX_BITS-1:0] idx_l;
  logic [2:0] issue_cnt;
  logic [1:0] recv_cnt;
  logic inv_seen;
  logic [TW-1:0] a_tag;
  logic [INDEX_BITS-1:0] a_idx;
  logic [1:0] a_word;
  logic hit, miss, last, resp_ok;
  assign a_tag = addr[15:3+INDEX_BITS];
  assign a_idx = addr[2+INDEX_BITS:3];
  assign a_word = addr[2:1];
  assign hit = valid[a_idx] && tags[a_idx] == a_tag;
  assign miss = state == IDLE && req && !addr[0] && !hit;
  assign last = state == FILL && mem_valid && recv_cnt == 2'd3;
  assign resp_ok = state == RESP && req && a_tag == tag_l && a_idx == idx_l;
  assign mem_rd = state == FILL && !issue_cnt[2];
  assign mem_addr = {tag_l, idx_l, issue_cnt[1:0], 1'b0};
  always_comb begin
    err = state == IDLE && req && addr[0];
    done = (state == IDLE && req && (addr[0] || hit)) || resp_ok;
    stall = miss || state == FILL;
    instr = (state == IDLE && req && !addr[0] && hit) ? data[a_idx][a_word] :
            resp_ok ? data[idx_l][a_word] : NOP;
    state_nx = miss ? FILL : state == FILL ? (last ? RESP : FILL) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      valid <= '0;
      issue_cnt <= '0;
      recv_cnt <= '0;
      inv_seen <= 1'b0;
      tag_l <= '0;
      idx_l <= '0;
    end else begin
      state <= state_nx;
      if (miss) begin
        tag_l <= a_tag;
        idx_l <= a_idx;
        issue_cnt <= '0;
        recv_cnt <= '0;
        inv_seen <= inv;
      end
      if (state == FILL) begin
        if (!issue_cnt[2]) issue_cnt <= issue_cnt + 3'd1;
        if (mem_valid) recv_cnt <= recv_cnt + 2'd1;
        if (inv) inv_seen <= 1'b1;
      end
      if (inv) valid <= '0;
      if (last && !inv_seen && !inv) valid[idx_l] <= 1'b1;
    end
  always_ff @(posedge clk) begin
    if (state == FILL && mem_valid) data[idx_l][recv_cnt] <= mem_data;
    if (last) tags[idx_l] <= tag_l;
  end
endmodule
